// File: rtl/id_issue_pkg.sv
// rtl/id_issue_pkg.sv - shared widths and pointer arithmetic for the decode/issue queue
// Purpose: width helpers used to size the lane-count, occupancy and pointer types,
//          and the modulo-Depth pointer advance shared by the top and the ring.
// Ports:   none (package).
package id_issue_pkg;

  // Bits needed to hold a lane count in [0, n].
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Bits needed to index [0, depth-1]; at least one bit so Depth=1 still elaborates.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // ptr < depth and add <= depth, so one conditional subtract is a full modulo.
  // Works for any depth, not only powers of two.
  function automatic int unsigned ptr_wrap(input int unsigned ptr,
                                           input int unsigned add,
                                           input int unsigned depth);
    int unsigned sum;
    sum = ptr + add;
    if (sum >= depth) sum = sum - depth;
    return sum;
  endfunction

endpackage

// File: rtl/id_issue_ring.sv
// rtl/id_issue_ring.sv - circular entry storage with NrPorts write and read lanes
// Purpose: Depth x PayloadWidth storage. Write lane i targets (tail_i+i) mod Depth,
//          read lane i returns (head_i+i) mod Depth. Storage clears on reset.
// Ports:   clk_i, rst_ni (async active-low); head_i/tail_i base pointers;
//          we_i per-lane write enables; wdata_i write payloads; rdata_o read payloads.
module id_issue_ring
  import id_issue_pkg::*;
#(
  parameter int unsigned NrPorts      = 2,
  parameter int unsigned Depth        = 4,
  parameter int unsigned PayloadWidth = 64,
  parameter int unsigned PtrW         = ptr_w(Depth)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [PtrW-1:0]                       head_i,
  input  logic [PtrW-1:0]                       tail_i,
  input  logic [NrPorts-1:0]                    we_i,
  input  logic [NrPorts-1:0][PayloadWidth-1:0]  wdata_i,
  output logic [NrPorts-1:0][PayloadWidth-1:0]  rdata_o
);

  logic [PayloadWidth-1:0]      mem_q [Depth];
  logic [NrPorts-1:0][PtrW-1:0] waddr;
  logic [NrPorts-1:0][PtrW-1:0] raddr;

  always_comb begin
    waddr   = '0;
    raddr   = '0;
    rdata_o = '0;
    for (int i = 0; i < NrPorts; i++) begin
      waddr[i]   = PtrW'(ptr_wrap(32'(tail_i), unsigned'(i), Depth));
      raddr[i]   = PtrW'(ptr_wrap(32'(head_i), unsigned'(i), Depth));
      rdata_o[i] = mem_q[raddr[i]];
    end
  end

  // NrPorts <= Depth, so the write lanes always hit distinct slots.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < Depth; s++) mem_q[s] <= '0;
    end else begin
      for (int s = 0; s < Depth; s++) begin
        for (int i = 0; i < NrPorts; i++) begin
          if (we_i[i] && (waddr[i] == PtrW'(s))) mem_q[s] <= wdata_i[i];
        end
      end
    end
  end

endmodule

// File: rtl/id_issue_queue.sv
// rtl/id_issue_queue.sv - multi-lane in-order buffer between decode and issue
// Purpose: accepts up to NrPorts decoded entries per cycle and presents up to
//          NrPorts oldest entries to issue. Space freed by this cycle's acks is
//          reusable in the same cycle. Supports intake stall and one-cycle flush.
// Ports:   clk_i, rst_ni (async active-low); flush_i discards all entries;
//          stall_i holds intake; in_valid_i/in_data_i/in_ready_o decode side;
//          out_valid_o/out_data_o/out_ack_i issue side; count_o occupancy.
module id_issue_queue
  import id_issue_pkg::*;
#(
  parameter int unsigned NrPorts      = 2,
  parameter int unsigned Depth        = 4,
  parameter int unsigned PayloadWidth = 64
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  flush_i,
  input  logic                                  stall_i,
  input  logic [NrPorts-1:0]                    in_valid_i,
  input  logic [NrPorts-1:0][PayloadWidth-1:0]  in_data_i,
  output logic [NrPorts-1:0]                    in_ready_o,
  output logic [NrPorts-1:0]                    out_valid_o,
  output logic [NrPorts-1:0][PayloadWidth-1:0]  out_data_o,
  input  logic [NrPorts-1:0]                    out_ack_i,
  output logic [$clog2(Depth+1)-1:0]            count_o
);

  localparam int unsigned PtrW  = ptr_w(Depth);
  localparam int unsigned LaneW = cnt_w(NrPorts);
  localparam int unsigned CntW  = $clog2(Depth + 1);

  typedef logic [PtrW-1:0]  ptr_t;
  typedef logic [LaneW-1:0] lane_cnt_t;
  typedef logic [CntW-1:0]  occ_t;

  ptr_t        head_q, head_d, tail_q, tail_d;
  occ_t        count_q, count_d;
  lane_cnt_t   n_ack, n_acc;
  int unsigned free_slots;
  logic        prefix;

  always_comb begin
    n_ack = '0;
    for (int i = 0; i < NrPorts; i++) n_ack = n_ack + lane_cnt_t'(out_ack_i[i]);

    free_slots = Depth - 32'(count_q) + 32'(n_ack);

    // Lane i is offered only if all older lanes are valid, keeping acceptance a
    // prefix. Readiness deliberately ignores the lane's own valid.
    in_ready_o = '0;
    n_acc      = '0;
    prefix     = 1'b1;
    for (int i = 0; i < NrPorts; i++) begin
      in_ready_o[i] = !flush_i && !stall_i && (unsigned'(i) < free_slots) && prefix;
      if (in_valid_i[i] && in_ready_o[i]) n_acc = n_acc + lane_cnt_t'(1);
      prefix = prefix & in_valid_i[i];
    end

    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = ptr_t'(ptr_wrap(32'(head_q), 32'(n_ack), Depth));
      tail_d  = ptr_t'(ptr_wrap(32'(tail_q), 32'(n_acc), Depth));
      count_d = count_q + occ_t'(n_acc) - occ_t'(n_ack);
    end
  end

  always_comb begin
    out_valid_o = '0;
    for (int i = 0; i < NrPorts; i++) out_valid_o[i] = (32'(i) < 32'(count_q));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

  // in_ready_o is already low during flush, so flush cycles write nothing.
  id_issue_ring #(
    .NrPorts      (NrPorts),
    .Depth        (Depth),
    .PayloadWidth (PayloadWidth),
    .PtrW         (PtrW)
  ) u_ring (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .head_i  (head_q),
    .tail_i  (tail_q),
    .we_i    (in_valid_i & in_ready_o),
    .wdata_i (in_data_i),
    .rdata_o (out_data_o)
  );

  a_ack_prefix: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (out_ack_i & (out_ack_i + NrPorts'(1))) == '0);
  a_ack_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (out_ack_i & ~out_valid_o) == '0);
  a_count_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
    32'(count_q) <= Depth);
  a_acc_free: assert property (@(posedge clk_i) disable iff (!rst_ni)
    32'(n_acc) <= free_slots);

endmodule
